// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed definitions: arbiter FSM encoding and index sizing.
package usb_fs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_GAP
    } arb_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_fs_rr_pick.sv
// Combinational winner search: first set request from start (mode=1)
// or from index 0 (mode=0), wrapping at the top.
module usb_fs_rr_pick #(
    parameter int NUM_EPS = 1,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_EPS-1:0] req,
    input  logic [IDX_W-1:0]   start,
    input  logic               mode,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    int base;

    assign base = mode ? int'(start) : 0;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_EPS; k++) begin
            if (!found && req[(base + k) % NUM_EPS]) begin
                found  = 1'b1;
                winner = IDX_W'((base + k) % NUM_EPS);
            end
        end
    end

endmodule

// File: rtl/usb_fs_ep_arb.sv
// Endpoint channel arbiter: one registered grant, a mandatory idle gap
// between owners, optional lock and hold limit.
module usb_fs_ep_arb
    import usb_fs_pkg::*;
#(
    parameter int NUM_EPS  = 1,
    parameter int DATA_W   = 8,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0,
    localparam int IDX_W   = idx_w(NUM_EPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_EPS-1:0]        ep_req,
    output logic [NUM_EPS-1:0]        ep_grant,
    input  logic [NUM_EPS*DATA_W-1:0] ep_data,
    input  logic                      lock,
    output logic [DATA_W-1:0]         arb_data,
    output logic                      arb_valid,
    output logic [IDX_W-1:0]          arb_idx,
    output logic                      hold_timeout
);

    localparam int CNT_W = idx_w(MAX_HOLD + 1);
    localparam logic [IDX_W-1:0] LAST_EP  = IDX_W'(NUM_EPS - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    arb_state_e         state, state_nx;
    logic [IDX_W-1:0]   idx_q, idx_nx;
    logic [IDX_W-1:0]   last_q, last_nx;
    logic [IDX_W-1:0]   start, winner;
    logic               found;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic               to_q, to_nx;
    logic [NUM_EPS-1:0] cur_oh, others;
    logic               own_req, force_rel;

    assign start = (last_q == LAST_EP) ? '0 : last_q + 1'b1;

    usb_fs_rr_pick #(
        .NUM_EPS (NUM_EPS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (ep_req),
        .start  (start),
        .mode   (RR_MODE != 0),
        .winner (winner),
        .found  (found)
    );

    assign cur_oh  = NUM_EPS'(1) << idx_q;
    assign others  = ep_req & ~cur_oh;
    assign own_req = ep_req[idx_q];
    // Forced release only when someone else is actually waiting.
    assign force_rel = (MAX_HOLD > 0) && (cnt_q == HOLD_MAX)
                     && !lock && (|others);

    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        last_nx  = last_q;
        cnt_nx   = cnt_q;
        to_nx    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nx = ST_GRANTED;
                    idx_nx   = winner;
                    last_nx  = winner;
                    cnt_nx   = '0;
                end
            end
            ST_GRANTED: begin
                if (force_rel) begin
                    state_nx = ST_GAP;
                    to_nx    = 1'b1;
                end else if (!lock && !own_req) begin
                    state_nx = ST_GAP;
                end else if (!lock && cnt_q != HOLD_MAX) begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            ST_GAP:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            idx_q  <= '0;
            last_q <= LAST_EP;
            cnt_q  <= '0;
            to_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            idx_q  <= idx_nx;
            last_q <= last_nx;
            cnt_q  <= cnt_nx;
            to_q   <= to_nx;
        end
    end

    assign arb_valid    = (state == ST_GRANTED);
    assign arb_idx      = idx_q;
    assign ep_grant     = arb_valid ? cur_oh : '0;
    assign hold_timeout = to_q;

    always_comb begin
        arb_data = '0;
        for (int i = 0; i < NUM_EPS; i++) begin
            if (arb_valid && idx_q == IDX_W'(i))
                arb_data = ep_data[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_usb_fs_ep_arb.sv
// Bench for usb_fs_ep_arb: round-robin/hold-limit and fixed-priority instances.
module tb_usb_fs_ep_arb;

    typedef struct {
        bit         sel;
        logic [3:0] req;
        logic       lock;
        logic [3:0] grant;
        logic       to;
    } vec_t;

    typedef struct {
        bit         sel;
        logic [3:0] grant;
        logic       to;
        int         num;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rr_req, fp_req;
    logic        rr_lock, fp_lock;
    logic [31:0] lanes_bus;
    logic [3:0]  rr_grant, fp_grant;
    logic [7:0]  rr_data, fp_data;
    logic        rr_valid, fp_valid;
    logic [1:0]  rr_idx, fp_idx;
    logic        rr_to, fp_to;

    logic [7:0]  lanes [4];
    vec_t        tv[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          vnum     = 0;

    always #5 clk = ~clk;

    assign lanes_bus = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

    usb_fs_ep_arb #(
        .NUM_EPS(4), .DATA_W(8), .RR_MODE(1), .MAX_HOLD(4)
    ) dut_rr (
        .clk(clk), .reset(reset), .ep_req(rr_req), .ep_grant(rr_grant),
        .ep_data(lanes_bus), .lock(rr_lock), .arb_data(rr_data),
        .arb_valid(rr_valid), .arb_idx(rr_idx), .hold_timeout(rr_to)
    );

    usb_fs_ep_arb #(
        .NUM_EPS(4), .DATA_W(8), .RR_MODE(0), .MAX_HOLD(0)
    ) dut_fp (
        .clk(clk), .reset(reset), .ep_req(fp_req), .ep_grant(fp_grant),
        .ep_data(lanes_bus), .lock(fp_lock), .arb_data(fp_data),
        .arb_valid(fp_valid), .arb_idx(fp_idx), .hold_timeout(fp_to)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = i;
        return r;
    endfunction

    task automatic check_dut(input bit sel, input logic [3:0] g,
                             input logic to, input string tag);
        logic [3:0] ag;
        logic [7:0] ad;
        logic       av, ato;
        logic [1:0] ai;
        logic [7:0] ed;
        ag  = sel ? fp_grant : rr_grant;
        ad  = sel ? fp_data  : rr_data;
        av  = sel ? fp_valid : rr_valid;
        ai  = sel ? fp_idx   : rr_idx;
        ato = sel ? fp_to    : rr_to;
        ed  = (|g) ? lanes[oh2idx(g)] : 8'h00;
        check({tag, " grant"}, 32'(ag), 32'(g));
        check({tag, " valid"}, 32'(av), 32'(|g));
        check({tag, " data"}, 32'(ad), 32'(ed));
        check({tag, " timeout"}, 32'(ato), 32'(to));
        if (|g)
            check({tag, " idx"}, 32'(ai), 32'(oh2idx(g)));
    endtask

    function automatic void add(input bit sel, input logic [3:0] req,
                                input logic lock, input logic [3:0] grant,
                                input logic to);
        vec_t v;
        v.sel = sel; v.req = req; v.lock = lock;
        v.grant = grant; v.to = to;
        tv.push_back(v);
    endfunction

    task automatic run_table();
        vec_t v;
        exp_t e;
        while (tv.size() > 0) begin
            v = tv.pop_front();
            rr_req  = v.sel ? 4'b0 : v.req;
            rr_lock = v.sel ? 1'b0 : v.lock;
            fp_req  = v.sel ? v.req : 4'b0;
            fp_lock = v.sel ? v.lock : 1'b0;
            e.sel = v.sel; e.grant = v.grant; e.to = v.to; e.num = vnum++;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_dut(e.sel, e.grant, e.to, $sformatf("v%0d", e.num));
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            n_checks++;
            if (!$onehot0(rr_grant) || !$onehot0(fp_grant)) begin
                n_fail++;
                $display("FAIL onehot: got rr=%b fp=%b expected at most one bit",
                         rr_grant, fp_grant);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1);
    end

    initial begin
        lanes[0] = 8'hA1; lanes[1] = 8'hB2;
        lanes[2] = 8'hC3; lanes[3] = 8'hD4;
        reset = 1'b0;
        rr_req = 4'b0101; rr_lock = 1'b0;
        fp_req = 4'b0110; fp_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_dut(0, 4'b0000, 1'b0, "rst_rr");
        check_dut(1, 4'b0000, 1'b0, "rst_fp");
        check("rst_rr idx", 32'(rr_idx), 32'd0);
        check("rst_fp idx", 32'(fp_idx), 32'd0);
        rr_req = 4'b0; fp_req = 4'b0;
        reset = 1'b1;

        // round-robin handoff with gap, lane data
        add(0, 4'b0101, 0, 4'b0001, 0);
        add(0, 4'b0101, 0, 4'b0001, 0);
        add(0, 4'b0100, 0, 4'b0000, 0);
        add(0, 4'b0100, 0, 4'b0000, 0);
        add(0, 4'b0100, 0, 4'b0100, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // hold limit forces release to waiting ep2
        add(0, 4'b0001, 0, 4'b0001, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0101, 0, 4'b0001, 0);
        add(0, 4'b0101, 0, 4'b0000, 1);
        add(0, 4'b0101, 0, 4'b0000, 0);
        add(0, 4'b0101, 0, 4'b0100, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // lock freezes the hold counter
        add(0, 4'b0001, 1, 4'b0001, 0);
        for (int i = 0; i < 9; i++) add(0, 4'b0101, 1, 4'b0001, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0101, 0, 4'b0001, 0);
        add(0, 4'b0101, 0, 4'b0000, 1);
        add(0, 4'b0101, 0, 4'b0000, 0);
        add(0, 4'b0101, 0, 4'b0100, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // req drop with simultaneous lock keeps grant
        add(0, 4'b1000, 0, 4'b1000, 0);
        add(0, 4'b0000, 1, 4'b1000, 0);
        add(0, 4'b0000, 1, 4'b1000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // saturated counter, late competitor
        add(0, 4'b0010, 0, 4'b0010, 0);
        for (int i = 0; i < 7; i++) add(0, 4'b0010, 0, 4'b0010, 0);
        add(0, 4'b0011, 0, 4'b0000, 1);
        add(0, 4'b0011, 0, 4'b0000, 0);
        add(0, 4'b0011, 0, 4'b0001, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        // fixed priority: index 1 always wins
        add(1, 4'b1110, 0, 4'b0010, 0);
        add(1, 4'b1100, 0, 4'b0000, 0);
        add(1, 4'b1110, 0, 4'b0000, 0);
        add(1, 4'b1110, 0, 4'b0010, 0);
        add(1, 4'b1100, 0, 4'b0000, 0);
        add(1, 4'b1110, 0, 4'b0000, 0);
        add(1, 4'b1110, 0, 4'b0010, 0);
        for (int i = 0; i < 6; i++) add(1, 4'b1110, 0, 4'b0010, 0);
        add(1, 4'b1100, 0, 4'b0000, 0);
        add(1, 4'b1100, 0, 4'b0000, 0);
        add(1, 4'b1100, 0, 4'b0100, 0);
        add(1, 4'b0000, 0, 4'b0000, 0);
        add(1, 4'b0000, 0, 4'b0000, 0);
        run_table();

        // asynchronous reset mid-grant
        rr_req = 4'b0010; rr_lock = 1'b0;
        @(posedge clk);
        #1;
        check_dut(0, 4'b0010, 1'b0, "pre_rst");
        #3;
        reset = 1'b0;
        #1;
        check_dut(0, 4'b0000, 1'b0, "async_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rr_req = 4'b0;
        reset = 1'b1;

        // last_idx restarts so the search begins at index 0
        add(0, 4'b1010, 0, 4'b0010, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b1000, 0, 4'b1000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_fs_ep_arb.md
USB_FS_EP_ARB -- requirements
Module: usb_fs_ep_arb

Interface
REQ-001 SHALL have parameter NUM_EPS, default 1, number of endpoint channels arbitrated (1..16).
REQ-002 SHALL have parameter DATA_W, default 8, width of each endpoint data lane.
REQ-003 SHALL have parameter RR_MODE, default 1, where 1 selects round-robin and 0 selects fixed priority (lowest index wins).
REQ-004 SHALL have parameter MAX_HOLD, default 0, maximum unlocked grant cycles before forced release, where 0 disables the limit.
REQ-005 SHALL define IDX_W = max(1, clog2(NUM_EPS)).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-008 SHALL have port ep_req, input, NUM_EPS bits: per-endpoint request.
REQ-009 SHALL have port ep_grant, output, NUM_EPS bits: registered one-hot grant.
REQ-010 SHALL have port ep_data, input, NUM_EPS*DATA_W bits: lane i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port lock, input, 1 bit: protocol engine freezes the current grant for the duration of a packet.
REQ-012 SHALL have port arb_data, output, DATA_W bits: lane of the granted endpoint.
REQ-013 SHALL have port arb_valid, output, 1 bit: a grant is active.
REQ-014 SHALL have port arb_idx, output, IDX_W bits: index of the granted endpoint.
REQ-015 SHALL have port hold_timeout, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-016 SHALL implement the FSM states IDLE, GRANTED and GAP.
REQ-017 In IDLE with any ep_req set, SHALL register the winner and enter GRANTED, so that ep_grant is asserted on the cycle after the request is sampled (1-cycle latency).
REQ-018 Winner selection SHALL follow the mode: RR_MODE=1 takes the first set request searching from last_idx+1 upward with wrap from NUM_EPS-1 to 0; RR_MODE=0 takes the lowest set index.
REQ-019 last_idx SHALL update to the winner on every grant.
REQ-020 In GRANTED, the grant SHALL be held while ep_req[arb_idx]=1 or lock=1.
REQ-021 When ep_req[arb_idx]=0 and lock=0, the FSM SHALL enter GAP and clear ep_grant on the next edge.
REQ-022 GAP SHALL last exactly 1 cycle with ep_grant=0, then return to IDLE; no back-to-back handoff is permitted.
REQ-023 When req drops and lock rises in the same cycle, lock SHALL take precedence and the grant SHALL be held.
REQ-024 The hold counter SHALL count GRANTED cycles with lock=0, freeze while lock=1, and clear on entry to GRANTED.
REQ-025 With MAX_HOLD>0, when the counter equals MAX_HOLD, lock=0 and any other ep_req is set, the block SHALL force GAP and pulse hold_timeout for 1 cycle.
REQ-026 With MAX_HOLD>0 and no competing request, the grant SHALL continue and the counter SHALL saturate at MAX_HOLD.
REQ-027 arb_data SHALL be a combinational mux of the ep_data lane selected by arb_idx, and SHALL be all-zero when arb_valid=0.
REQ-028 arb_valid SHALL equal (state==GRANTED), and ep_grant SHALL equal arb_valid ? onehot(arb_idx) : 0.
REQ-029 ep_grant SHALL never have more than one bit set.
REQ-030 With NUM_EPS=1, arb_idx SHALL be constant 0 and round-robin search SHALL degenerate to that single index.

Reset
REQ-031 While reset=0, SHALL force state=IDLE, ep_grant=0, arb_valid=0, arb_idx=0, arb_data=0, hold_timeout=0, last_idx=NUM_EPS-1 (so the first RR search starts at 0), and hold counter=0.
REQ-032 Reset asserted mid-grant SHALL drop ep_grant asynchronously, and the first arbitration after release SHALL use post-reset last_idx.

Structure
REQ-033 The FSM state encoding and the IDX_W computation function SHALL live in a shared usb_fs package.
REQ-034 A sub-module usb_fs_rr_pick (combinational: request vector, start index, mode -> winner index, found) SHALL be instantiated once.
REQ-035 This block SHALL replace usb_fs_in_arb and usb_fs_out_arb in the protocol engine with two instances.

Verification
REQ-036 Reset then ep_req=4'b0101, RR_MODE=1 -> grant 0001 next cycle; after req0 drops, 1 gap cycle, then grant 0100.
REQ-037 RR_MODE=0, ep_req=4'b1110 held, each granted req dropped for 1 cycle -> grant order 0010,0010,... (index 1 always wins).
REQ-038 MAX_HOLD=4, ep0 holds req, ep2 requests -> after 4 unlocked cycles hold_timeout=1 for 1 cycle, GAP, grant 0100.
REQ-039 Same as REQ-038 with lock=1 for 10 cycles -> no timeout during lock; timeout fires 4 unlocked cycles after lock drops.
REQ-040 ep_data lanes 8'hA1,8'hB2,8'hC3 with ep2 granted -> arb_data=8'hC3; during GAP -> arb_data=8'h00.
REQ-041 Assert reset=0 mid-grant -> ep_grant=0 immediately without waiting for a clock edge; after release, ep_req=4'b1000 RR search starts at index 0 and grants 1000.
